pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage CPU pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their `stall` and `flush` inputs and the PC hold. It detects three conditions and sequences the response to each:
- load-use hazards
- taken branches/jumps resolved in EX
- data-memory wait states

It also runs a small FSM that drains the pipeline on an external interrupt, then holds interrupts masked until `returni` retires.

## Interface
Parameters:
- `REG_AW`, default 4: register-index width.
- `DRAIN_CYCLES`, default 3: bubble cycles inserted before interrupt vectoring (1..3).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_load`  in  1  instruction in EX is a load (ID/EX `wb_sel_out`=1 and `reg_wr_out`=1).
- `ex_reg_dst`  in  REG_AW  destination register of the instruction in EX.
- `id_rs1`, `id_rs2`  in  REG_AW each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  corresponding source is actually read.
- `ex_branch_taken`  in  1  EX has resolved a taken branch, jump, call or return.
- `ex_returni`  in  1  `returni` is in EX (ID/EX `returni_out`).
- `mem_busy`  in  1  data memory is not ready this cycle.
- `int_req`  in  1  level interrupt request.
- `pc_hold`  out  1  PC keeps its current value.
- `stall_if_id`, `flush_if_id`  out  1 each  IF/ID register controls.
- `stall_id_ex`, `flush_id_ex`  out  1 each  ID/EX register controls.
- `stall_ex_mem`, `flush_ex_mem`  out  1 each  EX/MEM register controls.
- `stall_mem_wb`, `flush_mem_wb`  out  1 each  MEM/WB register controls.
- `int_ack`  out  1  one-cycle pulse; PC loads the interrupt vector.
- `int_active`  out  1  the handler is running and interrupts are masked.

## Operation
FSM states: RUN, DRAIN, VECTOR, ISR. A 2-bit `drain_cnt` accompanies DRAIN.

Stall and flush outputs are combinational from the inputs plus registered state. Priority is resolved per cycle, highest first:
1. **`mem_busy`**
   - `pc_hold`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem` = 1.
   - `flush_mem_wb` = 1, which injects a WB bubble.
   - All other hazards are ignored this cycle and the FSM does not advance.
2. **`ex_branch_taken`**
   - `flush_if_id` = 1 and `flush_id_ex` = 1.
   - `pc_hold` = 0, so the PC takes the target.
   - Overrides any load-use hazard in the same cycle.
3. **Load-use**
   - Detected when `ex_load` is set, `ex_reg_dst`≠0, and (`id_rs1_used` with `id_rs1`==`ex_reg_dst`, or `id_rs2_used` with `id_rs2`==`ex_reg_dst`).
   - Response: `pc_hold` = 1, `stall_if_id` = 1, `flush_id_ex` = 1, for exactly one bubble.
4. **Otherwise**: all stall and flush outputs are 0.

A flush and a stall are never both asserted on the same register.

FSM transitions:
- **RUN → DRAIN**: when `int_req` is set, `mem_busy`=0 and `ex_branch_taken`=0. `drain_cnt` loads DRAIN_CYCLES-1.
- **DRAIN**:
  - Outputs: `pc_hold` = 1, `flush_if_id` = 1. Older instructions keep flowing.
  - `drain_cnt` decrements per non-busy cycle and freezes while `mem_busy`.
  - A taken branch in EX additionally flushes ID/EX.
  - When `drain_cnt`==0 on a non-busy cycle, go to VECTOR.
- **VECTOR**: `int_ack` = 1 and `pc_hold` = 0 for one cycle, then go to ISR. If `mem_busy` is set, `int_ack` is suppressed and the FSM stays in VECTOR.
- **ISR**:
  - `int_active` = 1 and `int_req` is ignored.
  - Normal hazard handling applies.
  - `ex_returni` on a non-busy cycle → RUN.
- **Dropping `int_req`** after DRAIN is entered does not abort the sequence.

## Timing
- Zero-cycle latency from hazard inputs to stall/flush outputs. The outputs are decoded in the same cycle, so the registers act on the next edge.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load is in MEM and the hazard clears.
- Interrupt sequence:
  - cycle 0: `int_req` is sampled.
  - cycles 1..DRAIN_CYCLES: DRAIN.
  - cycle DRAIN_CYCLES+1: `int_ack` is asserted.
  - This totals DRAIN_CYCLES+1 cycles plus any `mem_busy` cycles.
- While `rst` is asserted, and as its immediate asynchronous effect:
  - state = RUN and `drain_cnt` = 0.
  - `pc_hold` = 1.
  - All `flush_*` = 1 and all `stall_*` = 0.
  - `int_ack` = 0 and `int_active` = 0.
- Reset asserted mid-DRAIN or mid-ISR aborts the sequence. After deassertion the block is in RUN with interrupts unmasked.

## Configuration
- Macro `HAZ_LOAD_USE_EN`.
  - **Defined**: load-use detection operates as described above.
  - **Undefined**: the load-use term is tied to 0. No bubbles are inserted, so software/compiler scheduling must avoid using a load result in the next instruction. All other behaviour is unchanged.

## Test plan
- **Load-use**: `ex_load`=1, `ex_reg_dst`=5, `id_rs2`=5, `id_rs2_used`=1. Expect `pc_hold`, `stall_if_id` and `flush_id_ex` high for one cycle. Repeat with `ex_reg_dst`=0 and expect no stall.
- **Branch vs load-use**: assert load-use and `ex_branch_taken` together. Expect `flush_if_id`=`flush_id_ex`=1, `stall_if_id`=0, `pc_hold`=0.
- **Memory wait**: `mem_busy`=1 for 3 cycles with a pending branch. Expect the three upper stalls, `pc_hold` and `flush_mem_wb` high for 3 cycles, then the branch flush on cycle 4.
- **Interrupt**: pulse `int_req` in RUN with DRAIN_CYCLES=3. Expect 3 cycles of `pc_hold`+`flush_if_id`, `int_ack` on cycle 4, and `int_active`=1 until `ex_returni`.
- **Mask and busy**: in ISR, `int_req`=1 produces no DRAIN. In DRAIN, `mem_busy`=1 for 2 cycles delays `int_ack` by exactly 2 cycles.
- **Reset mid-ISR**: assert `rst` while in ISR. Expect `int_active` to fall immediately and all flushes high. After release, `int_req` is accepted again.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch and memory-wait hazards plus interrupt drain FSM.
// Load-use bubbles are only generated when the HAZ_LOAD_USE_EN macro is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_reg_dst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_branch_taken,
    input  logic              ex_returni,
    input  logic              mem_busy,
    input  logic              int_req,
    output logic              pc_hold,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              stall_id_ex,
    output logic              flush_id_ex,
    output logic              stall_ex_mem,
    output logic              flush_ex_mem,
    output logic              stall_mem_wb,
    output logic              flush_mem_wb,
    output logic              int_ack,
    output logic              int_active
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        VECTOR,
        ISR
    } state_e;

    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       load_use;

`ifdef HAZ_LOAD_USE_EN
    assign load_use = ex_load && (ex_reg_dst != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_reg_dst)) ||
                       (id_rs2_used && (id_rs2 == ex_reg_dst)));
`else
    logic unused_load_use;
    assign load_use        = 1'b0;
    assign unused_load_use = ^{ex_load, ex_reg_dst, id_rs1, id_rs2, id_rs1_used, id_rs2_used};
`endif

    // NOTE: state flops use non-blocking assignments; all decode below is blocking in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // A busy data memory freezes the whole sequence, including the drain count.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (!mem_busy) begin
            unique case (state_q)
                RUN: begin
                    if (int_req && !ex_branch_taken) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 2'd0) state_d = VECTOR;
                    else                     drain_cnt_d = drain_cnt_q - 2'd1;
                end
                VECTOR:  state_d = ISR;
                ISR:     if (ex_returni) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        pc_hold      = 1'b0;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_mem_wb = 1'b0;
        int_ack      = 1'b0;
        int_active   = (state_q == ISR);

        if (rst) begin
            pc_hold      = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
            int_active   = 1'b0;
        end else if (mem_busy) begin
            pc_hold      = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else begin
            unique case (state_q)
                DRAIN: begin
                    pc_hold = 1'b1;
                    // A load-use bubble must hold the ID instruction, so IF/ID stalls instead of flushing.
                    if (ex_branch_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else begin
                        flush_if_id = 1'b1;
                    end
                end
                VECTOR: int_ack = 1'b1;
                default: begin
                    if (ex_branch_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table for hazard priority plus hand-written
// interrupt, memory-wait and reset sequences.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 4;

`ifdef HAZ_LOAD_USE_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    // Output vector bit positions.
    localparam logic [10:0] B_PC     = 11'h400;
    localparam logic [10:0] B_SIFID  = 11'h200;
    localparam logic [10:0] B_FIFID  = 11'h100;
    localparam logic [10:0] B_SIDEX  = 11'h080;
    localparam logic [10:0] B_FIDEX  = 11'h040;
    localparam logic [10:0] B_SEXMEM = 11'h020;
    localparam logic [10:0] B_FEXMEM = 11'h010;
    localparam logic [10:0] B_SMEMWB = 11'h008;
    localparam logic [10:0] B_FMEMWB = 11'h004;
    localparam logic [10:0] B_ACK    = 11'h002;
    localparam logic [10:0] B_ACT    = 11'h001;

    localparam logic [10:0] O_NONE  = 11'h000;
    localparam logic [10:0] O_LU    = B_PC | B_SIFID | B_FIDEX;
    localparam logic [10:0] O_BR    = B_FIFID | B_FIDEX;
    localparam logic [10:0] O_BUSY  = B_PC | B_SIFID | B_SIDEX | B_SEXMEM | B_FMEMWB;
    localparam logic [10:0] O_RST   = B_PC | B_FIFID | B_FIDEX | B_FEXMEM | B_FMEMWB;
    localparam logic [10:0] O_DRAIN = B_PC | B_FIFID;
    localparam logic [10:0] O_VEC   = B_ACK;
    localparam logic [10:0] O_ISR   = B_ACT;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_load;
    logic [REG_AW-1:0] ex_reg_dst;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              ex_branch_taken;
    logic              ex_returni;
    logic              mem_busy;
    logic              int_req;
    logic              pc_hold, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
    logic              stall_ex_mem, flush_ex_mem, stall_mem_wb, flush_mem_wb;
    logic              int_ack, int_active;
    logic [10:0]       out_vec;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_load         (ex_load),
        .ex_reg_dst      (ex_reg_dst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_branch_taken (ex_branch_taken),
        .ex_returni      (ex_returni),
        .mem_busy        (mem_busy),
        .int_req         (int_req),
        .pc_hold         (pc_hold),
        .stall_if_id     (stall_if_id),
        .flush_if_id     (flush_if_id),
        .stall_id_ex     (stall_id_ex),
        .flush_id_ex     (flush_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .flush_ex_mem    (flush_ex_mem),
        .stall_mem_wb    (stall_mem_wb),
        .flush_mem_wb    (flush_mem_wb),
        .int_ack         (int_ack),
        .int_active      (int_active)
    );

    assign out_vec = {pc_hold, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
                      stall_ex_mem, flush_ex_mem, stall_mem_wb, flush_mem_wb, int_ack, int_active};

    typedef struct {
        logic              ld;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              u1;
        logic              u2;
        logic              br;
        logic              busy;
        logic [10:0]       exp;
    } vec_t;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (pc,sIF,fIF,sID,fID,sEX,fEX,sMW,fMW,ack,act)",
                     name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ex_load         = 1'b0;
        ex_reg_dst      = '0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        ex_branch_taken = 1'b0;
        ex_returni      = 1'b0;
        mem_busy        = 1'b0;
        int_req         = 1'b0;
    endtask

    // Advance to the next falling edge, where the bench drives inputs and then samples 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle_check(input string name, input logic [10:0] exp);
        #1;
        check(name, out_vec, exp);
    endtask

    // Pulse int_req for one cycle from RUN; afterwards the FSM is in DRAIN with int_req low.
    task automatic start_interrupt(input string name);
        next_cycle();
        int_req = 1'b1;
        settle_check(name, O_NONE);
        next_cycle();
        int_req = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        vec_t lu_exp_rec;
        logic [10:0] lu_exp;
        lu_exp = LU_EN ? O_LU : O_NONE;

        //           ld    rd     rs1    rs2    u1    u2    br    busy  exp
        vecs[0]  = '{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, lu_exp};
        vecs[2]  = '{1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[3]  = '{1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[4]  = '{1'b1, 4'd7, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, lu_exp};
        vecs[5]  = '{1'b0, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[6]  = '{1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, O_BR};
        vecs[7]  = '{1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, O_BUSY};
        vecs[8]  = '{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_BR};
        vecs[9]  = '{1'b1, 4'd3, 4'd4, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[10] = '{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_BUSY};
        vecs[11] = '{1'b1, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};

        clear_inputs();
        rst = 1'b1;
        settle_check("reset_initial", O_RST);
        repeat (2) next_cycle();
        settle_check("reset_held", O_RST);
        rst = 1'b0;
        settle_check("reset_released", O_NONE);

        // Combinational hazard priority in RUN.
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            clear_inputs();
            ex_load         = vecs[i].ld;
            ex_reg_dst      = vecs[i].rd;
            id_rs1          = vecs[i].rs1;
            id_rs2          = vecs[i].rs2;
            id_rs1_used     = vecs[i].u1;
            id_rs2_used     = vecs[i].u2;
            ex_branch_taken = vecs[i].br;
            mem_busy        = vecs[i].busy;
            settle_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load-use hazard clears once the load leaves EX.
        next_cycle();
        clear_inputs();
        lu_exp_rec = vecs[1];
        ex_load = 1'b1; ex_reg_dst = lu_exp_rec.rd; id_rs2 = lu_exp_rec.rs2; id_rs2_used = 1'b1;
        settle_check("lu_bubble", lu_exp);
        next_cycle();
        ex_load = 1'b0;
        settle_check("lu_cleared", O_NONE);

        // Memory wait for three cycles with a pending branch, then the branch flush.
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            clear_inputs();
            ex_branch_taken = 1'b1;
            mem_busy        = 1'b1;
            settle_check($sformatf("memwait_c%0d", c), O_BUSY);
        end
        next_cycle();
        mem_busy = 1'b0;
        settle_check("memwait_branch", O_BR);
        next_cycle();
        clear_inputs();

        // Interrupt blocked by a branch in the request cycle.
        int_req = 1'b1; ex_branch_taken = 1'b1;
        settle_check("int_blocked_by_branch", O_BR);
        next_cycle();
        clear_inputs();
        settle_check("int_not_taken", O_NONE);

        // Full interrupt sequence; a branch during DRAIN also flushes ID/EX.
        start_interrupt("int_req_cycle");
        settle_check("drain_1", O_DRAIN);
        next_cycle();
        ex_branch_taken = 1'b1;
        settle_check("drain_2_branch", O_DRAIN | B_FIDEX);
        next_cycle();
        ex_branch_taken = 1'b0;
        settle_check("drain_3", O_DRAIN);
        next_cycle();
        settle_check("vector_ack", O_VEC);
        next_cycle();
        int_req = 1'b1;
        settle_check("isr_masked_1", O_ISR);
        next_cycle();
        settle_check("isr_masked_2", O_ISR);
        next_cycle();
        int_req = 1'b0; ex_branch_taken = 1'b1;
        settle_check("isr_branch", O_ISR | O_BR);
        next_cycle();
        ex_branch_taken = 1'b0; ex_returni = 1'b1; mem_busy = 1'b1;
        settle_check("isr_returni_busy", O_ISR | O_BUSY);
        next_cycle();
        mem_busy = 1'b0;
        settle_check("isr_returni", O_ISR);
        next_cycle();
        ex_returni = 1'b0;
        settle_check("back_to_run", O_NONE);

        // mem_busy for two DRAIN cycles delays int_ack by exactly two cycles; busy in VECTOR suppresses ack.
        start_interrupt("int2_req_cycle");
        settle_check("d2_drain_1", O_DRAIN);
        next_cycle();
        mem_busy = 1'b1;
        settle_check("d2_busy_1", O_BUSY);
        next_cycle();
        settle_check("d2_busy_2", O_BUSY);
        next_cycle();
        mem_busy = 1'b0;
        settle_check("d2_drain_2", O_DRAIN);
        next_cycle();
        settle_check("d2_drain_3", O_DRAIN);
        next_cycle();
        mem_busy = 1'b1;
        settle_check("d2_vector_busy", O_BUSY);
        next_cycle();
        mem_busy = 1'b0;
        settle_check("d2_vector_ack", O_VEC);
        next_cycle();
        settle_check("d2_isr", O_ISR);

        // Asynchronous reset in the middle of ISR.
        #2;
        rst = 1'b1;
        settle_check("rst_mid_isr", O_RST);
        next_cycle();
        rst = 1'b0;
        settle_check("after_rst_run", O_NONE);
        start_interrupt("int3_req_cycle");
        settle_check("int3_drain_1", O_DRAIN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
